// File: rtl/uart_gfa_pkg.sv
// uart_gfa_pkg: shared opcodes, status bit positions, response constants and engine states
// for the buffered UART peripheral.
package uart_gfa_pkg;
    localparam logic [2:0] OP_SEND   = 3'b001;
    localparam logic [2:0] OP_READ   = 3'b010;
    localparam logic [2:0] OP_STATUS = 3'b011;
    localparam logic [2:0] OP_SETDIV = 3'b100;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_IDLE   = 1;
    localparam int ST_RX_EMPTY  = 2;
    localparam int ST_RX_OVF    = 3;
    localparam int ST_FRAME_ERR = 4;

    localparam logic [31:0] RESP_EMPTY = 32'h0000_0100;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;
endpackage

// File: rtl/uart_gfa_fifo.sv
// uart_gfa_fifo: synchronous first-word-fall-through FIFO.
// Ports: clk_g/rst_g (sync, active-low), push/din write side, pop/dout read side
// (dout valid whenever !empty), full, empty, count (occupancy).
// A push while full is accepted when a pop happens in the same cycle.
module uart_gfa_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_g,
    input  logic                     rst_g,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             wr, rd;

    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign dout  = mem[rptr];

    always_ff @(posedge clk_g) begin
        if (!rst_g) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end

    always_ff @(posedge clk_g) begin
        if (wr) mem[wptr] <= din;
    end
endmodule

// File: rtl/uart_gfa_buffered.sv
// uart_gfa_buffered: command-driven UART with TX/RX FIFOs, programmable baud divisor
// and sticky error flags.
// Ports: clk_g/rst_g (sync, active-low); komut/komut_gecerli/komut_hazir command channel
// (opcode in komut[2:0]); veri/veri_gecerli/veri_hazir response channel; RX async serial
// input; TX serial output (idle high).
module uart_gfa_buffered
    import uart_gfa_pkg::*;
#(
    parameter int DIV_RESET = 868,
    parameter int DIV_W     = 16,
    parameter int TX_DEPTH  = 8,
    parameter int RX_DEPTH  = 8
) (
    input  logic        clk_g,
    input  logic        rst_g,
    input  logic [31:0] komut,
    input  logic        komut_gecerli,
    output logic        komut_hazir,
    output logic [31:0] veri,
    output logic        veri_gecerli,
    input  logic        veri_hazir,
    input  logic        RX,
    output logic        TX
);
    localparam int TCW = $clog2(TX_DEPTH) + 1;
    localparam int RCW = $clog2(RX_DEPTH) + 1;

    logic [DIV_W-1:0] div, new_div;
    logic [DIV_W-1:0] tx_cnt, tx_div, rx_cnt, rx_div;
    logic             tx_push, tx_pop, tx_full, tx_empty;
    logic             rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]       tx_dout, rx_dout, tx_sh, rx_sh;
    logic [TCW-1:0]   tx_count;
    logic [RCW-1:0]   rx_count;
    logic [2:0]       tx_bit, rx_bit, op;
    uart_state_t      tx_state, rx_state;
    logic             rx_s1, rx_s2, rx_prev, rx_ovf, frame_err;
    logic             acc, is_status, tx_end, rx_end;
    logic [31:0]      status;
    logic             unused;

    assign komut_hazir = !veri_gecerli && !tx_full;
    assign acc         = komut_gecerli && komut_hazir;
    assign op          = komut[2:0];
    assign is_status   = acc && op == OP_STATUS;
    assign new_div     = komut[DIV_W+7:8];
    assign tx_end      = tx_cnt == tx_div - 1'b1;
    assign rx_end      = rx_cnt == rx_div - 1'b1;
    assign tx_push     = acc && op == OP_SEND;
    assign tx_pop      = !tx_empty && (tx_state == S_IDLE || (tx_state == S_STOP && tx_end));
    assign rx_pop      = acc && op == OP_READ && !rx_empty;
    assign rx_push     = rx_state == S_STOP && rx_end && rx_s2;
    assign unused      = ^{komut[7:3], tx_count};

    always_comb begin
        status = '0;
        status[ST_TX_FULL]   = tx_full;
        status[ST_TX_IDLE]   = tx_empty && tx_state == S_IDLE;
        status[ST_RX_EMPTY]  = rx_empty;
        status[ST_RX_OVF]    = rx_ovf;
        status[ST_FRAME_ERR] = frame_err;
        status[15:8]         = 8'(rx_count);
    end

    uart_gfa_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_g(clk_g), .rst_g(rst_g), .push(tx_push), .din(komut[31:24]), .pop(tx_pop),
        .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    uart_gfa_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_g(clk_g), .rst_g(rst_g), .push(rx_push), .din(rx_sh), .pop(rx_pop),
        .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    // Command decode, response register, divisor and sticky flags.
    always_ff @(posedge clk_g) begin
        if (!rst_g) begin
            veri         <= '0;
            veri_gecerli <= 1'b0;
            div          <= DIV_W'(DIV_RESET);
            rx_ovf       <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            if (acc && op == OP_READ) begin
                veri         <= rx_empty ? RESP_EMPTY : {24'b0, rx_dout};
                veri_gecerli <= 1'b1;
            end else if (is_status) begin
                veri         <= status;
                veri_gecerli <= 1'b1;
            end else if (veri_hazir) begin
                veri_gecerli <= 1'b0;
            end
            if (acc && op == OP_SETDIV && new_div >= DIV_W'(4)) div <= new_div;
            // A flag raised in the same cycle as a STATUS read survives the clear.
            rx_ovf    <= (rx_push && rx_full && !rx_pop) || (rx_ovf && !is_status);
            frame_err <= (rx_state == S_STOP && rx_end && !rx_s2) || (frame_err && !is_status);
        end
    end

    // TX engine; the divisor is latched at every frame start.
    always_ff @(posedge clk_g) begin
        if (!rst_g) begin
            tx_state <= S_IDLE;
            TX       <= 1'b1;
            tx_cnt   <= '0;
            tx_div   <= DIV_W'(DIV_RESET);
            tx_bit   <= '0;
            tx_sh    <= '0;
        end else begin
            case (tx_state)
                S_IDLE: if (!tx_empty) begin
                    tx_state <= S_START;
                    TX       <= 1'b0;
                    tx_sh    <= tx_dout;
                    tx_div   <= div;
                    tx_cnt   <= '0;
                end
                S_START: if (tx_end) begin
                    tx_state <= S_DATA;
                    TX       <= tx_sh[0];
                    tx_sh    <= tx_sh >> 1;
                    tx_bit   <= '0;
                    tx_cnt   <= '0;
                end else tx_cnt <= tx_cnt + 1'b1;
                S_DATA: if (tx_end) begin
                    tx_cnt <= '0;
                    if (tx_bit == 3'd7) begin
                        tx_state <= S_STOP;
                        TX       <= 1'b1;
                    end else begin
                        TX     <= tx_sh[0];
                        tx_sh  <= tx_sh >> 1;
                        tx_bit <= tx_bit + 1'b1;
                    end
                end else tx_cnt <= tx_cnt + 1'b1;
                S_STOP: if (tx_end) begin
                    tx_cnt <= '0;
                    if (!tx_empty) begin
                        tx_state <= S_START;
                        TX       <= 1'b0;
                        tx_sh    <= tx_dout;
                        tx_div   <= div;
                    end else tx_state <= S_IDLE;
                end else tx_cnt <= tx_cnt + 1'b1;
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // RX engine; a frame can only start on a high-to-low edge, so after a framing
    // error the engine naturally waits for the line to return high.
    always_ff @(posedge clk_g) begin
        if (!rst_g) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_div   <= DIV_W'(DIV_RESET);
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            case (rx_state)
                S_IDLE: if (rx_prev && !rx_s2) begin
                    rx_state <= S_START;
                    rx_cnt   <= '0;
                    rx_div   <= div;
                end
                S_START: if (rx_cnt == rx_div >> 1) begin
                    rx_state <= rx_s2 ? S_IDLE : S_DATA;
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                end else rx_cnt <= rx_cnt + 1'b1;
                S_DATA: if (rx_end) begin
                    rx_cnt <= '0;
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_bit <= rx_bit + 1'b1;
                    if (rx_bit == 3'd7) rx_state <= S_STOP;
                end else rx_cnt <= rx_cnt + 1'b1;
                S_STOP: if (rx_end) rx_state <= S_IDLE;
                else rx_cnt <= rx_cnt + 1'b1;
                default: rx_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_gfa_buffered.sv
// tb_uart_gfa_buffered: randomized self-checking bench; TX waveform and RX FIFO/status
// behaviour are predicted from a frame-level model held in queues.
module tb_uart_gfa_buffered;
    import uart_gfa_pkg::*;

    localparam int DIV = 16;

    logic        clk_g = 0, rst_g = 0;
    logic [31:0] komut = 0;
    logic        komut_gecerli = 0, veri_hazir = 0, RX = 1;
    logic        komut_hazir, veri_gecerli, TX;
    logic [31:0] veri;

    uart_gfa_buffered #(.DIV_RESET(DIV), .DIV_W(16), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
        .clk_g(clk_g), .rst_g(rst_g), .komut(komut), .komut_gecerli(komut_gecerli),
        .komut_hazir(komut_hazir), .veri(veri), .veri_gecerli(veri_gecerli),
        .veri_hazir(veri_hazir), .RX(RX), .TX(TX)
    );

    always #5 clk_g = ~clk_g;

    int   cyc = 0;
    logic tx_hist [0:99999];
    always @(posedge clk_g) cyc <= cyc + 1;
    always @(negedge clk_g) if (cyc < 100000) tx_hist[cyc] = TX;

    int         checks = 0, errors = 0, last_acc = 0;
    logic       exp_tx[$];
    logic [7:0] rx_model[$];
    bit         m_ovf = 0, m_fe = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk_g);
    endtask

    task automatic do_cmd(input logic [31:0] c);
        int n = 0;
        komut = c;
        komut_gecerli = 1;
        while (komut_hazir !== 1'b1 && n < 5000) begin
            @(negedge clk_g);
            n++;
        end
        checks++;
        if (komut_hazir !== 1'b1) begin
            errors++;
            $display("FAIL cmd_accept: komut_hazir=%b after %0d cycles, required 1", komut_hazir, n);
        end
        last_acc = cyc + 1;
        @(negedge clk_g);
        komut_gecerli = 0;
        komut = $urandom;
    endtask

    task automatic get_resp(output logic [31:0] r);
        checks++;
        if (veri_gecerli !== 1'b1) begin
            errors++;
            $display("FAIL resp_valid: veri_gecerli=%b, required 1", veri_gecerli);
        end
        r = veri;
        veri_hazir = 1;
        @(negedge clk_g);
        veri_hazir = 0;
        checks++;
        if (veri_gecerli !== 1'b0) begin
            errors++;
            $display("FAIL resp_release: veri_gecerli=%b, required 0", veri_gecerli);
        end
    endtask

    task automatic add_frame(input logic [7:0] b, input int d);
        repeat (d) exp_tx.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (d) exp_tx.push_back(b[i]);
        repeat (d) exp_tx.push_back(1'b1);
    endtask

    task automatic check_tx(input int start, input string name);
        int   bad = 0, first = -2, n = 0;
        int   len = exp_tx.size();
        logic e;
        while (cyc < start + len + 2 && n < 50000) begin
            @(negedge clk_g);
            n++;
        end
        for (int i = -1; i <= len; i++) begin
            e = (i < 0 || i >= len) ? 1'b1 : exp_tx[i];
            if (tx_hist[start+i] !== e) begin
                if (first == -2) first = i;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d of %0d TX cycles differ from the expected waveform, first at offset %0d (got %b)",
                     name, bad, len + 2, first, tx_hist[start+first]);
        end
        exp_tx.delete();
    endtask

    task automatic rx_inject(input logic [7:0] b, input bit stop);
        RX = 0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            tick(DIV);
        end
        RX = stop;
        tick(DIV);
        RX = 1;
        tick(4);
        if (!stop) m_fe = 1;
        else if (rx_model.size() < 8) rx_model.push_back(b);
        else m_ovf = 1;
    endtask

    task automatic read_check(input string name);
        logic [31:0] r, e;
        e = rx_model.size() == 0 ? 32'h0000_0100 : {24'b0, rx_model.pop_front()};
        do_cmd(32'(OP_READ));
        get_resp(r);
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL %s: veri=%h, required %h", name, r, e);
        end
    endtask

    task automatic status_check(input string name);
        logic [31:0] r, e;
        e = {16'b0, 8'(rx_model.size()), 3'b0, m_fe, m_ovf, rx_model.size() == 0, 1'b1, 1'b0};
        m_fe = 0;
        m_ovf = 0;
        do_cmd(32'(OP_STATUS));
        get_resp(r);
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL %s: status=%h, required %h", name, r, e);
        end
    endtask

    task automatic test_reset;
        rst_g = 0;
        tick(3);
        checks++;
        if ({TX, komut_hazir, veri_gecerli} !== 3'b110 || veri !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: TX/hazir/gecerli=%b veri=%h, required 110 / 00000000",
                     {TX, komut_hazir, veri_gecerli}, veri);
        end
        rst_g = 1;
        tick(2);
        status_check("reset_status");
    endtask

    task automatic test_send_byte;
        int s;
        do_cmd({8'hA5, 21'h0, OP_SEND});
        s = last_acc + 1;
        add_frame(8'hA5, DIV);
        check_tx(s, "send_a5_frame");
    endtask

    task automatic test_back_to_back;
        logic [7:0] b[9];
        int s, n = 0;
        foreach (b[i]) b[i] = 8'($urandom);
        foreach (b[i]) begin
            do_cmd({b[i], 21'h0, OP_SEND});
            if (i == 0) s = last_acc + 1;
        end
        checks++;
        if (komut_hazir !== 1'b0) begin
            errors++;
            $display("FAIL tx_full_hazir: komut_hazir=%b, required 0", komut_hazir);
        end
        while (komut_hazir !== 1'b1 && n < 1000) begin
            @(negedge clk_g);
            n++;
        end
        checks++;
        if (cyc != s + 10 * DIV) begin
            errors++;
            $display("FAIL tx_full_release: komut_hazir rose at cycle %0d, required %0d", cyc, s + 10 * DIV);
        end
        foreach (b[i]) add_frame(b[i], DIV);
        check_tx(s, "back_to_back_frames");
    endtask

    task automatic test_setdiv;
        int s;
        do_cmd({8'h5A, 21'h0, OP_SEND});
        s = last_acc + 1;
        tick(40);
        do_cmd((32'd32 << 8) | 32'(OP_SETDIV));
        do_cmd({8'hC3, 21'h0, OP_SEND});
        add_frame(8'h5A, DIV);
        add_frame(8'hC3, 32);
        check_tx(s, "setdiv_mid_frame");
        do_cmd((32'd2 << 8) | 32'(OP_SETDIV));
        do_cmd({8'h0F, 21'h0, OP_SEND});
        s = last_acc + 1;
        add_frame(8'h0F, 32);
        check_tx(s, "setdiv_2_ignored");
    endtask

    task automatic test_reset_mid_tx;
        int s;
        do_cmd({8'h00, 21'h0, OP_SEND});
        tick(30);
        do_cmd(32'(OP_STATUS));
        rst_g = 0;
        @(negedge clk_g);
        checks++;
        if ({TX, komut_hazir, veri_gecerli} !== 3'b110 || veri !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_tx: TX/hazir/gecerli=%b veri=%h, required 110 / 00000000",
                     {TX, komut_hazir, veri_gecerli}, veri);
        end
        tick(2);
        rst_g = 1;
        tick(3);
        do_cmd({8'h96, 21'h0, OP_SEND});
        s = last_acc + 1;
        add_frame(8'h96, DIV);
        check_tx(s, "post_reset_div");
    endtask

    task automatic test_rx_read;
        logic [31:0] held;
        rx_inject(8'h3C, 1);
        do_cmd(32'(OP_READ));
        held = veri;
        tick(3);
        checks++;
        if (veri_gecerli !== 1'b1 || veri !== held || komut_hazir !== 1'b0) begin
            errors++;
            $display("FAIL resp_hold: gecerli=%b veri=%h hazir=%b, required 1 %h 0",
                     veri_gecerli, veri, komut_hazir, held);
        end
        get_resp(held);
        checks++;
        if (held !== {24'b0, rx_model[0]}) begin
            errors++;
            $display("FAIL read_3c: veri=%h, required 0000003c", held);
        end
        void'(rx_model.pop_front());
        read_check("read_empty");
    endtask

    task automatic test_rx_overflow;
        for (int i = 0; i < 9; i++) rx_inject(8'($urandom), 1);
        status_check("status_overflow");
        status_check("status_overflow_cleared");
        for (int i = 0; i < 9; i++) read_check("drain_read");
    endtask

    task automatic test_frame_err_glitch;
        rx_inject(8'h81, 0);
        status_check("status_frame_err");
        RX = 0;
        tick(3);
        RX = 1;
        tick(200);
        status_check("status_after_glitch");
    endtask

    task automatic test_random;
        logic [7:0] b[3];
        int s;
        foreach (b[i]) b[i] = 8'($urandom);
        foreach (b[i]) begin
            do_cmd({b[i], 21'h0, OP_SEND});
            if (i == 0) s = last_acc + 1;
        end
        foreach (b[i]) add_frame(b[i], DIV);
        check_tx(s, "random_tx_frames");
        for (int i = 0; i < 14; i++) begin
            case ($urandom_range(0, 4))
                0, 1: rx_inject(8'($urandom), 1);
                2: rx_inject(8'($urandom), $urandom_range(0, 3) != 0);
                3: read_check("random_read");
                default: status_check("random_status");
            endcase
        end
        status_check("random_final_status");
    endtask

    initial begin
        test_reset;
        test_send_byte;
        test_back_to_back;
        test_setdiv;
        test_reset_mid_tx;
        test_rx_read;
        test_rx_overflow;
        test_frame_err_glitch;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
